// File: rtl/pk_hasti.sv
// Shared AHB-Lite (HASTI) bus types, HSIZE encodings and the byte-lane helper.
package pk_hasti;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_t;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    // Misaligned half/word addresses are folded onto their natural lanes.
    function automatic logic [3:0] hasti_byte_en(input logic [2:0] hsize, input logic [1:0] addr);
        logic [3:0] mask;
        mask = 4'b0000;
        case (hsize)
            HSIZE_BYTE: mask = 4'b0001 << addr;
            HSIZE_HALF: mask = addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: mask = 4'b1111;
            default:    mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/hasti_sram_array.sv
// DEPTH x 32 single-clock SRAM with per-byte write enables and a registered read port.
module hasti_sram_array #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic [3:0]               we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [31:0]              wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    // A read and write to the same word on one edge returns the old contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/hasti_sram_slave.sv
// AHB-Lite (HASTI) SRAM responder with configurable wait states and write-to-read forwarding.
// Define HASTI_SRAM_ALIGN_CHECK_EN to reject misaligned half/word accesses with an ERROR response.
module hasti_sram_slave
    import pk_hasti::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WINDOW_BITS = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic [1:0]  htrans,
    input  logic        hmastlock,
    input  logic        hready,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);

    localparam int AW        = $clog2(DEPTH);
    localparam int BYTE_BITS = AW + 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [3:0]           wait_cnt;
    logic [3:0]           wait_cnt_next;

    logic [BYTE_BITS-1:0] addr_q;
    logic                 write_q;
    logic [2:0]           size_q;
    logic                 err_q;

    logic                 rd_zero;
    logic [3:0]           fwd_mask;
    logic [31:0]          fwd_data;
    logic [31:0]          array_q;

    htrans_t              trans;
    hresp_t               resp;
    logic                 ready;
    logic                 accept;
    logic                 size_err;
    logic                 range_err;
    logic                 align_err;
    logic                 req_err;
    logic                 commit;
    logic                 rd_go;
    logic                 fwd_hit;
    logic [3:0]           wr_lanes;
    logic [3:0]           wr_en;
    logic                 unused;

    assign unused = ^{hburst, hprot, hmastlock, haddr[31:WINDOW_BITS]};

    assign trans  = htrans_t'(htrans);
    assign ready  = (state == ST_WAIT) ? (wait_cnt == 4'd0) : (state != ST_ERR1);
    assign accept = hsel && hready && ready && (trans == HTRANS_NONSEQ || trans == HTRANS_SEQ);

    assign size_err = (hsize > HSIZE_WORD);

    generate
        if (WINDOW_BITS > BYTE_BITS) begin : g_range
            assign range_err = |haddr[WINDOW_BITS-1:BYTE_BITS];
        end else begin : g_no_range
            assign range_err = 1'b0;
        end
    endgenerate

`ifdef HASTI_SRAM_ALIGN_CHECK_EN
    assign align_err = ((hsize == HSIZE_HALF) && haddr[0]) ||
                       ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));
`else
    assign align_err = 1'b0;
`endif

    assign req_err = size_err || range_err || align_err;

    // A write lands on the edge that closes its OKAY data phase.
    assign commit   = ready && (state == ST_DATA || state == ST_WAIT) && write_q && !err_q;
    assign wr_lanes = hasti_byte_en(size_q, addr_q[1:0]);
    assign wr_en    = commit ? wr_lanes : 4'b0000;

    assign rd_go   = accept && !hwrite && !req_err;
    assign fwd_hit = commit && (addr_q[BYTE_BITS-1:2] == haddr[BYTE_BITS-1:2]);

    assign resp      = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign hresp     = resp;
    assign hreadyout = ready;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= 3'd0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (accept) begin
                addr_q  <= haddr[BYTE_BITS-1:0];
                write_q <= hwrite;
                size_q  <= hsize;
                err_q   <= req_err;
            end
        end
    end

    // Error responses skip the wait counter entirely.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        if (state == ST_ERR1) begin
            state_next = ST_ERR2;
        end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
            wait_cnt_next = wait_cnt - 4'd1;
        end else if (accept) begin
            if (req_err) begin
                state_next = ST_ERR1;
            end else if (WAIT_STATES > 0) begin
                state_next    = ST_WAIT;
                wait_cnt_next = 4'(WAIT_STATES);
            end else begin
                state_next = ST_DATA;
            end
        end else begin
            state_next = ST_IDLE;
        end
    end

    // Lanes being committed alongside a read of the same word override the stale array data.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            rd_zero  <= 1'b1;
            fwd_mask <= 4'b0000;
            fwd_data <= 32'h0;
        end else if (rd_go) begin
            rd_zero  <= 1'b0;
            fwd_mask <= fwd_hit ? wr_lanes : 4'b0000;
            fwd_data <= hwdata;
        end
    end

    always_comb begin
        hrdata = 32'h0;
        if (!rd_zero) begin
            for (int i = 0; i < 4; i++) begin
                hrdata[8*i +: 8] = fwd_mask[i] ? fwd_data[8*i +: 8] : array_q[8*i +: 8];
            end
        end
    end

    hasti_sram_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (hclk),
        .we    (wr_en),
        .waddr (addr_q[BYTE_BITS-1:2]),
        .wdata (hwdata),
        .re    (rd_go),
        .raddr (haddr[BYTE_BITS-1:2]),
        .rdata (array_q)
    );

endmodule

// File: tb/tb_hasti_sram_slave.sv
// Scoreboard bench for hasti_sram_slave: one zero-wait DEPTH=512 instance and one WAIT_STATES=2 instance.
module tb_hasti_sram_slave;

    localparam int DEPTH0 = 512;
    localparam int DEPTHW = 1024;
    localparam int WS_W   = 2;

    typedef struct {
        logic        err;
        logic        chk;
        logic [31:0] rdata;
        int          waits;
    } exp_t;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel0;
    logic        hselw;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [31:0] hwdata;

    logic [31:0] hrdata0;
    logic        rdy0;
    logic        resp0;
    logic [31:0] hrdataw;
    logic        rdyw;
    logic        respw;

    exp_t        sb0[$];
    exp_t        sbw[$];
    logic [31:0] model[int];
    int          lowCnt[2];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 hclk = ~hclk;

    hasti_sram_slave #(
        .DEPTH       (DEPTH0),
        .WINDOW_BITS (12),
        .WAIT_STATES (0)
    ) dut0 (
        .hclk      (hclk),
        .hreset    (hreset),
        .hsel      (hsel0),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hburst    (3'b000),
        .hprot     (4'b0011),
        .htrans    (htrans),
        .hmastlock (1'b0),
        .hready    (rdy0),
        .hwdata    (hwdata),
        .hrdata    (hrdata0),
        .hreadyout (rdy0),
        .hresp     (resp0)
    );

    hasti_sram_slave #(
        .DEPTH       (DEPTHW),
        .WINDOW_BITS (12),
        .WAIT_STATES (WS_W)
    ) dutw (
        .hclk      (hclk),
        .hreset    (hreset),
        .hsel      (hselw),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hburst    (3'b000),
        .hprot     (4'b0011),
        .htrans    (htrans),
        .hmastlock (1'b0),
        .hready    (rdyw),
        .hwdata    (hwdata),
        .hrdata    (hrdataw),
        .hreadyout (rdyw),
        .hresp     (respw)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] laneMask(input logic [2:0] size, input logic [1:0] a);
        case (size)
            3'd0:    return 4'b0001 << a;
            3'd1:    return a[1] ? 4'b1100 : 4'b0011;
            3'd2:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic expectErr(input int d, input logic [31:0] addr, input logic [2:0] size);
        logic e;
        int   bytes;
        bytes = (d == 0) ? DEPTH0 * 4 : DEPTHW * 4;
        e = (size > 3'd2) || (int'(addr[11:0]) >= bytes);
`ifdef HASTI_SRAM_ALIGN_CHECK_EN
        if (size == 3'd1 && addr[0]) e = 1'b1;
        if (size == 3'd2 && addr[1:0] != 2'b00) e = 1'b1;
`endif
        return e;
    endfunction

    task automatic driveAddr(input int d, input logic [31:0] addr, input logic wr, input logic [2:0] size);
        hsel0  = (d == 0);
        hselw  = (d == 1);
        haddr  = addr;
        hwrite = wr;
        hsize  = size;
        htrans = 2'b10;
    endtask

    task automatic waitAccept(input int d, output logic ok);
        logic rs;
        ok = 1'b0;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge hclk);
            rs = (d == 0) ? rdy0 : rdyw;
            @(posedge hclk);
            ok = rs;
        end
        #1;
        if (!ok) checkOutput("accept", {31'b0, ok}, 32'd1);
    endtask

    task automatic idle(input int n);
        hsel0  = 1'b0;
        hselw  = 1'b0;
        htrans = 2'b00;
        repeat (n) @(posedge hclk);
        #1;
    endtask

    // Issues one transfer, updates the reference memory and queues the expected data phase.
    task automatic applyStimulus(input int d, input logic [31:0] addr, input logic wr,
                                 input logic [2:0] size, input logic [31:0] wdata);
        logic       ok;
        exp_t       e;
        int         key;
        logic [3:0] m;
        driveAddr(d, addr, wr, size);
        waitAccept(d, ok);
        hwdata  = wdata;
        e.err   = expectErr(d, addr, size);
        e.waits = e.err ? 1 : ((d == 0) ? 0 : WS_W);
        e.chk   = 1'b0;
        e.rdata = 32'h0;
        key     = d * 65536 + int'(addr[13:2]);
        if (!ok) return;
        if (wr && !e.err) begin
            m = laneMask(size, addr[1:0]);
            if (m == 4'hf || model.exists(key)) begin
                logic [31:0] w;
                w = model.exists(key) ? model[key] : 32'h0;
                for (int i = 0; i < 4; i++) begin
                    if (m[i]) w[8*i +: 8] = wdata[8*i +: 8];
                end
                model[key] = w;
            end
        end else if (!wr && !e.err && model.exists(key)) begin
            e.chk   = 1'b1;
            e.rdata = model[key];
        end
        if (d == 0) sb0.push_back(e);
        else        sbw.push_back(e);
    endtask

    task automatic monitorPhase(input int d);
        exp_t        e;
        logic        r;
        logic        rs;
        logic [31:0] rd;
        int          n;
        n = (d == 0) ? sb0.size() : sbw.size();
        if (n == 0) return;
        e  = (d == 0) ? sb0[0] : sbw[0];
        r  = (d == 0) ? rdy0 : rdyw;
        rs = (d == 0) ? resp0 : respw;
        rd = (d == 0) ? hrdata0 : hrdataw;
        if (!r) begin
            checkOutput("resp_stall", {31'b0, rs}, {31'b0, e.err});
            lowCnt[d]++;
            if (lowCnt[d] > e.waits + 8) begin
                checkOutput("stall_bound", 32'(lowCnt[d]), 32'(e.waits));
                if (d == 0) void'(sb0.pop_front());
                else        void'(sbw.pop_front());
                lowCnt[d] = 0;
            end
        end else begin
            if (d == 0) void'(sb0.pop_front());
            else        void'(sbw.pop_front());
            checkOutput("resp", {31'b0, rs}, {31'b0, e.err});
            checkOutput("stall_cycles", 32'(lowCnt[d]), 32'(e.waits));
            if (e.chk) checkOutput("rdata", rd, e.rdata);
            lowCnt[d] = 0;
        end
    endtask

    always @(negedge hclk) begin
        if (!hreset) begin
            for (int d = 0; d < 2; d++) monitorPhase(d);
        end
    end

    initial begin
        logic ok;
        hreset = 1'b0;
        hsel0  = 1'b0;
        hselw  = 1'b0;
        haddr  = 32'h0;
        hwrite = 1'b0;
        hsize  = 3'd0;
        htrans = 2'b00;
        hwdata = 32'h0;
        lowCnt[0] = 0;
        lowCnt[1] = 0;

        #2 hreset = 1'b1;
        repeat (2) @(posedge hclk);
        #1;
        checkOutput("rst_ready0", {31'b0, rdy0}, 32'd1);
        checkOutput("rst_resp0", {31'b0, resp0}, 32'd0);
        checkOutput("rst_rdata0", hrdata0, 32'h0);
        checkOutput("rst_readyw", {31'b0, rdyw}, 32'd1);
        checkOutput("rst_respw", {31'b0, respw}, 32'd0);
        checkOutput("rst_rdataw", hrdataw, 32'h0);
        @(negedge hclk);
        hreset = 1'b0;
        @(posedge hclk);
        #1;

        // Back-to-back word write then read of the same word.
        applyStimulus(0, 32'h2000_0010, 1'b1, 3'd2, 32'hdead_beef);
        applyStimulus(0, 32'h2000_0010, 1'b0, 3'd2, 32'h0);
        idle(2);

        // Word, byte overwrite, then read.
        applyStimulus(0, 32'h2000_0020, 1'b1, 3'd2, 32'h1122_3344);
        applyStimulus(0, 32'h2000_0022, 1'b1, 3'd0, 32'h00aa_0000);
        applyStimulus(0, 32'h2000_0020, 1'b0, 3'd2, 32'h0);
        idle(2);

        // Upper halfword write merged into an existing word.
        applyStimulus(0, 32'h2000_0024, 1'b1, 3'd2, 32'hcafe_f00d);
        applyStimulus(0, 32'h2000_0026, 1'b1, 3'd1, 32'h5566_0000);
        applyStimulus(0, 32'h2000_0024, 1'b0, 3'd2, 32'h0);
        idle(2);
        applyStimulus(0, 32'h2000_0010, 1'b0, 3'd2, 32'h0);
        idle(2);

        // Out-of-range and illegal-size accesses followed by good reads.
        applyStimulus(0, 32'h2000_0ffc, 1'b0, 3'd2, 32'h0);
        applyStimulus(0, 32'h2000_0020, 1'b0, 3'd2, 32'h0);
        applyStimulus(0, 32'h2000_0010, 1'b1, 3'd3, 32'h0000_0000);
        applyStimulus(0, 32'h2000_0010, 1'b0, 3'd2, 32'h0);
        idle(2);

        // Misaligned word and halfword writes.
        applyStimulus(0, 32'h2000_0000, 1'b1, 3'd2, 32'h0102_0304);
        idle(1);
        applyStimulus(0, 32'h2000_0002, 1'b1, 3'd2, 32'h0bad_f00d);
        idle(2);
        applyStimulus(0, 32'h2000_0000, 1'b0, 3'd2, 32'h0);
        applyStimulus(0, 32'h2000_0030, 1'b1, 3'd2, 32'ha5a5_a5a5);
        applyStimulus(0, 32'h2000_0031, 1'b1, 3'd1, 32'h0000_beef);
        applyStimulus(0, 32'h2000_0030, 1'b0, 3'd2, 32'h0);
        idle(2);

        // Wait-stated instance: write then read back.
        applyStimulus(1, 32'h2000_0040, 1'b1, 3'd2, 32'h1234_5678);
        applyStimulus(1, 32'h2000_0040, 1'b0, 3'd2, 32'h0);
        idle(6);

        // Reset while a write is stalled: the write must be dropped.
        driveAddr(1, 32'h2000_0040, 1'b1, 3'd2);
        waitAccept(1, ok);
        hwdata = 32'hffff_ffff;
        hselw  = 1'b0;
        htrans = 2'b00;
        @(negedge hclk);
        checkOutput("wait_low", {31'b0, rdyw}, 32'd0);
        #2 hreset = 1'b1;
        #1;
        checkOutput("arst_ready", {31'b0, rdyw}, 32'd1);
        checkOutput("arst_resp", {31'b0, respw}, 32'd0);
        checkOutput("arst_rdata", hrdataw, 32'h0);
        sb0.delete();
        sbw.delete();
        lowCnt[0] = 0;
        lowCnt[1] = 0;
        @(posedge hclk);
        #1 hreset = 1'b0;
        applyStimulus(1, 32'h2000_0040, 1'b0, 3'd2, 32'h0);
        idle(6);

        // Randomised mix over a small initialised region.
        for (int i = 64; i < 72; i++) begin
            applyStimulus(0, 32'h2000_0000 + 32'(i * 4), 1'b1, 3'd2, $urandom);
        end
        for (int k = 0; k < 24; k++) begin
            logic [31:0] a;
            logic        wr;
            logic [2:0]  sz;
            a  = 32'h2000_0000 + 32'($urandom_range(64, 71) * 4) + 32'($urandom_range(0, 3));
            wr = 1'($urandom_range(0, 1));
            sz = 3'($urandom_range(0, 2));
            if (!wr) begin
                a[1:0] = 2'b00;
                sz     = 3'd2;
            end
            applyStimulus(0, a, wr, sz, $urandom);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(2);

        for (int c = 0; c < 50 && (sb0.size() + sbw.size()) != 0; c++) begin
            @(posedge hclk);
        end
        #1;
        checkOutput("drain", 32'(sb0.size() + sbw.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
